ioctl_loader: RTL

- Sits between hps_io and the game core / top-level glue. Demultiplexes the ioctl download stream into four destinations:
  - ROM write stream, buffered and back-pressured.
  - Palette PROM writes.
  - DIP switch bytes.
  - The hardware-type byte.
- Tracks the download session, paces hps_io through ioctl_wait and reports byte count and checksum at end of load.
- Replaces the ad-hoc DIP, palette and hwtype registers in the top level.

---
 rtl/ioctl_loader_if.sv | 19 +
 rtl/ioctl_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader_if.sv
// ioctl download bus between hps_io (master) and the loader (slave).
interface ioctl_loader_if;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait
   );
endinterface

// File: rtl/ioctl_loader.sv
// Demultiplexes the hps_io download stream into a back-pressured ROM write
// stream, palette PROM writes, DIP bytes and the hardware-type byte.
module ioctl_loader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [24:0] PAL_BASE   = 25'h18000,
   parameter logic [7:0]  DIP_INDEX  = 8'd254,
   parameter logic [7:0]  HW_INDEX   = 8'd1
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   ioctl_loader_if.slave      ioctl,
   output logic               rom_download,
   output logic               rom_wr,
   output logic [24:0]        rom_addr,
   output logic [7:0]         rom_data,
   input  logic               rom_ready,
   output logic               pal_wr,
   output logic [4:0]         pal_addr,
   output logic [7:0]         pal_data,
   output logic [63:0]        dip_bus,
   output logic [7:0]         hwtype,
   output logic               load_done,
   output logic [24:0]        byte_count,
   output logic [15:0]        checksum
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } entry_t;

   state_t          state, state_nxt;
   entry_t          mem [FIFO_DEPTH];
   entry_t          push_ent, head_nxt;
   logic [AW-1:0]   wptr, rptr, rptr_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic            rom_sel, full, push, pop, wait_nxt;

   assign rom_sel  = ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd0) && (state == LOAD);
   assign full     = (count == CW'(FIFO_DEPTH));
   // rom_wr mirrors (count != 0), so a handshake always pops a live entry
   assign pop      = rom_wr && rom_ready;
   // a push into a full FIFO is only legal when the head leaves the same cycle
   assign push     = rom_sel && (!full || pop);
   assign push_ent = '{addr: ioctl.ioctl_addr, data: ioctl.ioctl_dout};

   // Next occupancy and next head; a push into an emptying FIFO bypasses storage
   always_comb begin
      count_nxt = count + CW'(push) - CW'(pop);
      rptr_nxt  = pop ? rptr + AW'(1) : rptr;
      head_nxt  = mem[rptr_nxt];
      if (push && ((count - CW'(pop)) == '0))
         head_nxt = push_ent;
   end

   // Stall the source one entry early, and hold it off while a new index-0
   // session waits for the previous one to drain
   always_comb begin
      wait_nxt = (count_nxt >= CW'(FIFO_DEPTH - 1)) ||
                 (ioctl.ioctl_download && (ioctl.ioctl_index == 8'd0) && (state_nxt != LOAD));
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk_sys) begin
      if (push)
         mem[wptr] <= push_ent;
   end

   // FIFO pointers and the registered head presented to the core
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wptr             <= '0;
         rptr             <= '0;
         count            <= '0;
         rom_wr           <= 1'b0;
         rom_addr         <= '0;
         rom_data         <= '0;
         ioctl.ioctl_wait <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         rptr             <= rptr_nxt;
         count            <= count_nxt;
         rom_wr           <= (count_nxt != '0);
         ioctl.ioctl_wait <= wait_nxt;
         if (count_nxt != '0) begin
            rom_addr <= head_nxt.addr;
            rom_data <= head_nxt.data;
         end
      end
   end

   // Session statistics, cleared as a new index-0 session starts
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         byte_count <= '0;
         checksum   <= '0;
      end else if (state == IDLE && state_nxt == LOAD) begin
         byte_count <= '0;
         checksum   <= '0;
      end else if (push) begin
         byte_count <= byte_count + 25'd1;
         checksum   <= checksum + {8'd0, ioctl.ioctl_dout};
      end
   end

   // Palette PROM writes, one cycle behind the source strobe, never stalled
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pal_wr   <= 1'b0;
         pal_addr <= '0;
         pal_data <= '0;
      end else begin
         pal_wr <= rom_sel && (ioctl.ioctl_addr[24:5] == PAL_BASE[24:5]);
         if (rom_sel && (ioctl.ioctl_addr[24:5] == PAL_BASE[24:5])) begin
            pal_addr <= ioctl.ioctl_addr[4:0];
            pal_data <= ioctl.ioctl_dout;
         end
      end
   end

   // DIP bytes and hardware type, accepted regardless of session state
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dip_bus <= '0;
         hwtype  <= 8'hFF;
      end else if (ioctl.ioctl_wr) begin
         if (ioctl.ioctl_index == DIP_INDEX && ioctl.ioctl_addr[24:3] == '0)
            dip_bus[{ioctl.ioctl_addr[2:0], 3'b000} +: 8] <= ioctl.ioctl_dout;
         if (ioctl.ioctl_index == HW_INDEX)
            hwtype <= ioctl.ioctl_dout;
      end
   end

   // Session state register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Session transitions; DRAIN ends only once the last ROM write is taken
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ioctl.ioctl_download && ioctl.ioctl_index == 8'd0) state_nxt = LOAD;
         LOAD:    if (!ioctl.ioctl_download) state_nxt = DRAIN;
         DRAIN:   if (count == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Session outputs; load_done is high for the single DRAIN->IDLE cycle
   always_comb begin
      rom_download = (state != IDLE);
      load_done    = (state == DRAIN) && (count == '0);
   end

endmodule
